// File: rtl/ldpc_sched_pkg.sv
// Shared types and helpers for the QC-LDPC shift scheduler and its shifter wrapper.
package ldpc_sched_pkg;

  // Tag row/col fields are sized for the largest base graph; instances use the low bits.
  localparam int TAG_ROW_W = 8;
  localparam int TAG_COL_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic                 valid;
    logic [TAG_ROW_W-1:0] row;
    logic [TAG_COL_W-1:0] col;
    logic                 row_end;
  } tag_t;

  localparam int TAG_W = $bits(tag_t);

  // One register per barrel-shifter mux level.
  function automatic int shift_lat(input int maxz);
    return $clog2(maxz);
  endfunction

endpackage

// File: rtl/ldpc_tag_delay.sv
// Fixed-depth delay line for scheduler tags, matched to the shifter latency.
module ldpc_tag_delay
  import ldpc_sched_pkg::*;
#(
  parameter int DEPTH = 7
) (
  input  logic             CLK,
  input  logic             clr_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic [TAG_W-1:0] tag_o
);

  tag_t pipe_q [DEPTH];

  always_ff @(posedge CLK) begin
    if (clr_i) begin
      // NOTE: these are individual flops, not a RAM, so every stage is cleared to drop in-flight tags.
      for (int i = 0; i < DEPTH; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      pipe_q[0] <= tag_t'(tag_i);
      for (int i = 1; i < DEPTH; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign tag_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/ldpc_shift_scheduler.sv
// Walks one QC-LDPC base-matrix pass through the pipelined circular shifter.
// Define LDPC_SCHED_PERF_EN to add the perf_cycles / perf_issued counters.
module ldpc_shift_scheduler
  import ldpc_sched_pkg::*;
#(
  parameter  int MAXZ      = 81,
  parameter  int NUM_ROWS  = 12,
  parameter  int NUM_COLS  = 24,
  localparam int SH_W      = $clog2(MAXZ),
  localparam int Z_W       = $clog2(MAXZ) + 1,
  localparam int ROW_W     = $clog2(NUM_ROWS),
  localparam int COL_W     = $clog2(NUM_COLS),
  localparam int SHIFT_LAT = shift_lat(MAXZ),
  localparam int CNT_W     = $clog2(SHIFT_LAT + 1)
) (
  input  logic             CLK,
  input  logic             rst_n,
  input  logic             start,
  input  logic             hold,
  input  logic [Z_W-1:0]   z_size,
  output logic             busy,
  output logic             done,
  output logic             shift_err,
  output logic [ROW_W-1:0] bm_row,
  output logic [COL_W-1:0] bm_col,
  input  logic             bm_null,
  input  logic [SH_W-1:0]  bm_shift,
  input  logic [MAXZ-1:0]  blk_data,
  output logic [MAXZ-1:0]  sh_data,
  output logic [SH_W-1:0]  sh_shift,
  output logic             out_valid,
  output logic [ROW_W-1:0] out_row,
  output logic [COL_W-1:0] out_col,
  output logic             out_row_end
`ifdef LDPC_SCHED_PERF_EN
  ,
  output logic [31:0]      perf_cycles,
  output logic [15:0]      perf_issued
`endif
);

  state_t             state_q, state_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [Z_W-1:0]     z_q, z_d;
  logic               err_q, err_d;

  logic               issue;
  logic               shift_bad;
  logic               last_col;
  tag_t               tag_in;
  tag_t               tag_out;
  logic               unused_tag;

  assign issue     = (state_q == RUN) && !hold;
  assign last_col  = (col_q == COL_W'(NUM_COLS - 1));
  assign shift_bad = !bm_null && ({1'b0, bm_shift} >= z_q);

  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      state_q <= IDLE;
      row_q   <= '0;
      col_q   <= '0;
      cnt_q   <= '0;
      z_q     <= '0;
      err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so every register samples pre-edge values.
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      cnt_q   <= cnt_d;
      z_q     <= z_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    // NOTE: every target is defaulted first so no branch can infer a latch.
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    cnt_d   = cnt_q;
    z_d     = z_q;
    err_d   = err_q | (issue & shift_bad);
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          row_d   = '0;
          col_d   = '0;
          z_d     = z_size;
        end
      end
      RUN: begin
        if (!hold) begin
          if (last_col) begin
            col_d = '0;
            if (row_q == ROW_W'(NUM_ROWS - 1)) begin
              row_d   = '0;
              cnt_d   = '0;
              state_d = DRAIN;
            end else begin
              row_d = row_q + 1'b1;
            end
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (cnt_q == CNT_W'(SHIFT_LAT - 1)) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The shifter registers its inputs, so the issue slot is driven combinationally.
  always_comb begin
    busy     = (state_q == RUN) || (state_q == DRAIN);
    done     = (state_q == DONE);
    sh_data  = '0;
    sh_shift = '0;
    tag_in   = '0;
    if (issue) begin
      tag_in.valid   = !bm_null && !shift_bad;
      tag_in.row     = TAG_ROW_W'(row_q);
      tag_in.col     = TAG_COL_W'(col_q);
      tag_in.row_end = last_col;
      if (!bm_null) begin
        sh_data  = blk_data;
        sh_shift = bm_shift;
      end
    end
  end

  ldpc_tag_delay #(
    .DEPTH(SHIFT_LAT)
  ) u_tag_delay (
    .CLK  (CLK),
    .clr_i(!rst_n),
    .tag_i(tag_in),
    .tag_o(tag_out)
  );

  assign bm_row      = row_q;
  assign bm_col      = col_q;
  assign shift_err   = err_q;
  assign out_valid   = tag_out.valid;
  assign out_row     = tag_out.row[ROW_W-1:0];
  assign out_col     = tag_out.col[COL_W-1:0];
  assign out_row_end = tag_out.row_end;

  // Row/col bits above this instance's widths are always zero.
  assign unused_tag = ^tag_out;

`ifdef LDPC_SCHED_PERF_EN
  logic [31:0] perf_cycles_q;
  logic [15:0] perf_issued_q;

  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      perf_cycles_q <= '0;
      perf_issued_q <= '0;
    end else if ((state_q == IDLE) && start) begin
      perf_cycles_q <= '0;
      perf_issued_q <= '0;
    end else begin
      if (busy) perf_cycles_q <= perf_cycles_q + 32'd1;
      if (tag_in.valid) perf_issued_q <= perf_issued_q + 16'd1;
    end
  end

  assign perf_cycles = perf_cycles_q;
  assign perf_issued = perf_issued_q;
`endif

endmodule

// File: tb/tb_ldpc_shift_scheduler.sv
// Self-checking bench: randomized base matrices and hold patterns against a pass-level model.
module tb_ldpc_shift_scheduler;

  localparam int MAXZ = 81;
  localparam int NR   = 2;
  localparam int NC   = 3;
  localparam int LAT  = 7;
  localparam int SW   = $clog2(MAXZ);
  localparam int ZW   = SW + 1;
  localparam int RW   = $clog2(NR);
  localparam int CW   = $clog2(NC);
  localparam int MAXC = 64;

  logic            CLK = 1'b0;
  logic            rst_n, start, hold;
  logic [ZW-1:0]   z_size;
  logic            busy, done, shift_err;
  logic [RW-1:0]   bm_row;
  logic [CW-1:0]   bm_col;
  logic            bm_null;
  logic [SW-1:0]   bm_shift;
  logic [MAXZ-1:0] blk_data, sh_data;
  logic [SW-1:0]   sh_shift;
  logic            out_valid, out_row_end;
  logic [RW-1:0]   out_row;
  logic [CW-1:0]   out_col;
`ifdef LDPC_SCHED_PERF_EN
  logic [31:0]     perf_cycles;
  logic [15:0]     perf_issued;
`endif

  always #5 CLK = ~CLK;

  ldpc_shift_scheduler #(
    .MAXZ(MAXZ), .NUM_ROWS(NR), .NUM_COLS(NC)
  ) dut (
    .CLK(CLK), .rst_n(rst_n), .start(start), .hold(hold), .z_size(z_size),
    .busy(busy), .done(done), .shift_err(shift_err),
    .bm_row(bm_row), .bm_col(bm_col), .bm_null(bm_null), .bm_shift(bm_shift),
    .blk_data(blk_data), .sh_data(sh_data), .sh_shift(sh_shift),
    .out_valid(out_valid), .out_row(out_row), .out_col(out_col), .out_row_end(out_row_end)
`ifdef LDPC_SCHED_PERF_EN
    , .perf_cycles(perf_cycles), .perf_issued(perf_issued)
`endif
  );

  // Base-matrix ROM and per-column input blocks
  logic            null_m  [NR][NC];
  logic [SW-1:0]   shift_m [NR][NC];
  logic [MAXZ-1:0] blk_m   [NC];

  assign bm_null  = null_m[bm_row][bm_col];
  assign bm_shift = shift_m[bm_row][bm_col];
  assign blk_data = blk_m[bm_col];

  typedef struct {
    bit v;
    int row;
    int col;
    bit re;
  } slot_t;

  slot_t           exp_out      [MAXC];
  bit              is_issue     [MAXC];
  logic [MAXZ-1:0] exp_sh_data  [MAXC];
  logic [SW-1:0]   exp_sh_shift [MAXC];
  bit              hold_sched   [MAXC];
  bit              err_sticky;
  int              n_checks = 0;
  int              n_errors = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [MAXZ-1:0] rand_blk();
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    return t[MAXZ-1:0];
  endfunction

  task automatic fill_rom(input int zlim, input int null_pct);
    for (int r = 0; r < NR; r++) begin
      for (int k = 0; k < NC; k++) begin
        null_m[r][k]  = ($urandom_range(0, 99) < null_pct);
        shift_m[r][k] = SW'($urandom_range(0, zlim - 1));
      end
    end
    for (int k = 0; k < NC; k++) blk_m[k] = rand_blk();
  endtask

  task automatic clear_hold();
    for (int i = 0; i < MAXC; i++) hold_sched[i] = 1'b0;
  endtask

  // Entered and left #1 after a rising edge; cycle 0 is the start cycle.
  task automatic run_pass(input logic [ZW-1:0] z, input bit noise);
    int c, idx, nrun, done_c, first_bad, n_valid;
    c = 1; idx = 0; first_bad = -1; n_valid = 0;
    for (int i = 0; i < MAXC; i++) begin
      exp_out[i]  = '{0, 0, 0, 0};
      is_issue[i] = 1'b0;
    end
    while (idx < NR * NC) begin
      if (!hold_sched[c]) begin
        int  r, k;
        bit  nl, bad;
        r   = idx / NC;
        k   = idx % NC;
        nl  = null_m[r][k];
        bad = !nl && (int'(shift_m[r][k]) >= int'(z));
        if (bad && first_bad < 0) first_bad = c;
        if (!nl && !bad) n_valid++;
        exp_out[c + LAT] = '{!nl && !bad, r, k, k == NC - 1};
        is_issue[c]      = 1'b1;
        exp_sh_data[c]   = nl ? '0 : blk_m[k];
        exp_sh_shift[c]  = nl ? '0 : shift_m[r][k];
        idx++;
      end
      c++;
    end
    nrun   = c - 1;
    done_c = nrun + LAT + 1;

    for (int cy = 0; cy <= done_c + 1; cy++) begin
      start  = (cy == 0) || (noise && cy < done_c && $urandom_range(0, 3) == 0);
      hold   = hold_sched[cy];
      z_size = (cy == 0 || !noise) ? z : ZW'($urandom_range(0, 255));
      @(negedge CLK);
      check("busy", busy, cy >= 1 && cy <= nrun + LAT);
      check("done", done, cy == done_c);
      check("out_valid", out_valid, exp_out[cy].v);
      check("out_row_end", out_row_end, exp_out[cy].re);
      if (exp_out[cy].v || exp_out[cy].re) begin
        check("out_row", out_row, exp_out[cy].row);
        check("out_col", out_col, exp_out[cy].col);
      end
      if (is_issue[cy]) begin
        check("sh_data", sh_data, exp_sh_data[cy]);
        check("sh_shift", sh_shift, exp_sh_shift[cy]);
      end
      check("shift_err", shift_err, err_sticky || (first_bad >= 0 && cy > first_bad));
`ifdef LDPC_SCHED_PERF_EN
      if (cy == done_c + 1) begin
        check("perf_cycles", perf_cycles, nrun + LAT);
        check("perf_issued", perf_issued, n_valid);
      end
`endif
      @(posedge CLK); #1;
    end
    if (first_bad >= 0) err_sticky = 1'b1;
    start = 1'b0;
    hold  = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_shift_err"}, shift_err, 0);
    check({tag, "_bm_row"}, bm_row, 0);
    check({tag, "_bm_col"}, bm_col, 0);
    check({tag, "_sh_data"}, sh_data, 0);
    check({tag, "_sh_shift"}, sh_shift, 0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_row"}, out_row, 0);
    check({tag, "_out_col"}, out_col, 0);
    check({tag, "_out_row_end"}, out_row_end, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n_done, n_busy, n_vld;
    rst_n = 1'b0; start = 1'b0; hold = 1'b0; z_size = '0;
    err_sticky = 1'b0;
    clear_hold();
    fill_rom(MAXZ, 0);
    repeat (2) @(posedge CLK);
    #1;
    check_idle_outputs("reset");
    rst_n = 1'b1;
    @(posedge CLK); #1;

    // Clean pass, then single null, then a fully null row
    fill_rom(MAXZ, 0);
    run_pass(ZW'(MAXZ), 1'b0);
    fill_rom(MAXZ, 0);
    null_m[0][1] = 1'b1;
    run_pass(ZW'(MAXZ), 1'b0);
    fill_rom(MAXZ, 0);
    for (int k = 0; k < NC; k++) null_m[1][k] = 1'b1;
    run_pass(ZW'(MAXZ), 1'b0);

    // Two hold cycles while the address sits at (1,0)
    fill_rom(MAXZ, 0);
    hold_sched[4] = 1'b1;
    hold_sched[5] = 1'b1;
    run_pass(ZW'(MAXZ), 1'b0);
    clear_hold();

    // Out-of-range shift against a small Z
    fill_rom(27, 0);
    shift_m[0][2] = SW'(30);
    run_pass(ZW'(27), 1'b0);

    // Reset in the middle of RUN, asserted together with start
    fill_rom(MAXZ, 0);
    start = 1'b1; z_size = ZW'(MAXZ);
    @(posedge CLK); #1;
    start = 1'b0;
    repeat (2) begin
      @(posedge CLK); #1;
    end
    rst_n = 1'b0; start = 1'b1;
    @(posedge CLK); #1;
    check_idle_outputs("midrst");
    rst_n = 1'b1; start = 1'b0;
    err_sticky = 1'b0;
    n_done = 0; n_busy = 0; n_vld = 0;
    repeat (20) begin
      @(negedge CLK);
      if (done) n_done++;
      if (busy) n_busy++;
      if (out_valid) n_vld++;
    end
    check("midrst_no_done", n_done, 0);
    check("midrst_no_busy", n_busy, 0);
    check("midrst_no_stale_tags", n_vld, 0);
    @(posedge CLK); #1;
    fill_rom(MAXZ, 0);
    run_pass(ZW'(MAXZ), 1'b0);

    // Randomized passes: nulls, bad shifts, holds, stray start and z_size noise
    for (int p = 0; p < 16; p++) begin
      int z;
      z = $urandom_range(1, MAXZ);
      fill_rom(MAXZ, 25);
      clear_hold();
      for (int i = 0; i < 40; i++) hold_sched[i] = ($urandom_range(0, 3) == 0);
      run_pass(ZW'(z), 1'b1);
      if (p % 6 == 5) begin
        rst_n = 1'b0;
        @(posedge CLK); #1;
        rst_n = 1'b1;
        err_sticky = 1'b0;
        check("rand_rst_shift_err", shift_err, 0);
      end
    end
    clear_hold();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ldpc_shift_scheduler.md
Name: ldpc_shift_scheduler

Overview:
Sequences one QC-LDPC base-matrix pass through the pipelined circular shifter. Scans base-matrix entries in row-major order and skips null entries. For each non-null entry it issues one zero-padded Z-bit block plus its shift value to the shifter. A tag pipeline, matched to the shifter latency, realigns row/column/valid metadata with the shifter output for the downstream check-node accumulator.

Parameters:
MAXZ, 81, padded lifting size; shifter data width
NUM_ROWS, 12, base-matrix rows
NUM_COLS, 24, base-matrix columns
SHIFT_LAT, $clog2(MAXZ), shifter latency in cycles; fixed, one register per mux level

Ports:
CLK  in  1  clock
rst_n  in  1  reset
start  in  1  begin one pass; sampled only in IDLE
hold  in  1  pause issuing; in-flight words keep draining
z_size  in  $clog2(MAXZ)+1  active Z; sampled at start
busy  out  1  high in RUN and DRAIN
done  out  1  one-cycle pulse at end of pass
shift_err  out  1  sticky; set when bm_shift >= z_size on a non-null entry
bm_row  out  $clog2(NUM_ROWS)  base-matrix read row
bm_col  out  $clog2(NUM_COLS)  base-matrix read column
bm_null  in  1  entry at (bm_row,bm_col) is -1; combinational ROM, same cycle
bm_shift  in  $clog2(MAXZ)  entry shift value, same cycle
blk_data  in  MAXZ  input block for column bm_col, same cycle
sh_data  out  MAXZ  to shifter in_data
sh_shift  out  $clog2(MAXZ)  to shifter shift_val
out_valid  out  1  shifter out_data holds a valid rotated block
out_row  out  $clog2(NUM_ROWS)  row tag aligned with shifter output
out_col  out  $clog2(NUM_COLS)  column tag aligned with shifter output
out_row_end  out  1  final column of out_row has passed; may assert with out_valid=0

Behaviour:
- Reset: rst_n is synchronous, active-low, clock CLK. All outputs reset to 0, state goes to IDLE, counters clear, tag pipeline clears, shift_err clears. Reset mid-pass drops all in-flight tags; no done pulse is produced.
- States:
  - IDLE: start=1 latches z_size, sets (row,col)=(0,0), moves to RUN next cycle.
  - RUN: each cycle with hold=0 consumes entry (row,col) and advances col, wrapping to 0 with row+1.
    - On the last entry (NUM_ROWS-1, NUM_COLS-1), moves to DRAIN.
    - hold=1: address frozen, issued slot has valid=0 and row_end=0.
  - DRAIN: counts SHIFT_LAT cycles, then moves to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE.
- start outside IDLE is ignored. start and reset together: reset wins.
- Issue slot (RUN, hold=0):
  - Non-null: sh_data=blk_data, sh_shift=bm_shift, tag valid=1.
  - Null: sh_data=0, sh_shift=0, tag valid=0.
  - row_end=1 when col==NUM_COLS-1, regardless of null.
  - sh_data and sh_shift are combinational from inputs, because the shifter registers internally.
- Tag pipeline: SHIFT_LAT-deep shift register of {valid,row,col,row_end}, advancing every cycle. Stage SHIFT_LAT drives the out_* ports, so a tag appears exactly SHIFT_LAT cycles after its issue cycle.
- Shift-value check: bm_shift >= z_size on a non-null entry sets shift_err. That entry is still issued with tag valid=0.
- Pass length with hold never asserted: busy is high for NUM_ROWS*NUM_COLS + SHIFT_LAT cycles; done follows the last busy cycle.
- hold during DRAIN has no effect.

Optional Feature:
LDPC_SCHED_PERF_EN:
- Defined: adds outputs perf_cycles (32b, counts busy cycles) and perf_issued (16b, counts valid issues). Both clear at start and hold their value after done.
- Undefined: neither port nor counter exists.

Decomposition:
- Package ldpc_sched_pkg holds:
  - state enum {IDLE,RUN,DRAIN,DONE}
  - packed tag struct {valid,row,col,row_end}
  - localparam SHIFT_LAT derivation function, for reuse by the shifter wrapper
- One sub-module, ldpc_tag_delay: a parameterised-depth tag shift register with synchronous clear.

Test Plan:
- MAXZ=81, NUM_ROWS=2, NUM_COLS=3, no nulls, start at cycle 0 -> first out_valid at cycle 1+7=8 with row0/col0; busy high for 13 cycles; done at cycle 14.
- Entry (0,1) null -> slot at cycle 9 has out_valid=0; out_row_end=1 at (0,2) and (1,2); no shift_err.
- Row 1 all null -> three out_valid=0 slots; out_row_end=1 on the third; done timing unchanged.
- hold high for 2 cycles at (1,0) -> two invalid slots inserted; done delayed by exactly 2 cycles; issued tag order unchanged.
- z_size=27, bm_shift=30 at (0,2) -> shift_err=1 sticky; that slot has out_valid=0; other tags unaffected.
- rst_n low for 1 cycle mid-RUN -> all outputs 0 next cycle; no done pulse; a new start completes a full pass normally.
